// File: rtl/swdb_pkg.sv
// rtl/swdb_pkg.sv - default constants shared by the switch debouncer files
package swdb_pkg;

  localparam int SWDB_WIDTH           = 8;
  localparam int SWDB_DEBOUNCE_CYCLES = 500000;
  localparam int SWDB_CNT_W           = 20;

endpackage

// File: rtl/switch_debounce_bit.sv
// rtl/switch_debounce_bit.sv - two-flop synchroniser, stability counter and edge pulses for one line
import swdb_pkg::*;

module switch_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = SWDB_DEBOUNCE_CYCLES,
  parameter int CNT_W           = SWDB_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic sw_db,
  output logic sw_rise,
  output logic sw_fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             s;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b0;
      s       <= 1'b0;
      cnt     <= '0;
      sw_db   <= 1'b0;
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
    end else begin
      sync1   <= sw_raw;
      s       <= sync1;
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
      if (s == sw_db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Accepting the new level also clears the count, so it can never wrap.
        sw_db   <= s;
        cnt     <= '0;
        sw_rise <= s;
        sw_fall <= ~s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - per-line debouncer array with sticky pending flags and irq
// Pending/irq logic is built only when SWITCH_DEBOUNCER_IRQ_EN is defined.
import swdb_pkg::*;

module switch_debouncer #(
  parameter int WIDTH           = SWDB_WIDTH,
  parameter int DEBOUNCE_CYCLES = SWDB_DEBOUNCE_CYCLES,
  parameter int CNT_W           = SWDB_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic [WIDTH-1:0] clr_pending,
  input  logic [WIDTH-1:0] irq_mask,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic [WIDTH-1:0] pending,
  output logic             irq
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .sw_raw (sw_raw[i]),
      .sw_db  (sw_db[i]),
      .sw_rise(sw_rise[i]),
      .sw_fall(sw_fall[i])
    );
  end

`ifdef SWITCH_DEBOUNCER_IRQ_EN
  // A new edge overrides a same-cycle clear so no event is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_pending) | sw_rise | sw_fall;
    end
  end

  assign irq = |(pending & irq_mask);
`else
  logic unused_irq_inputs;

  assign unused_irq_inputs = ^{clr_pending, irq_mask};
  assign pending           = '0;
  assign irq               = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - directed and randomized checks of switch_debouncer against a window model
module tb_switch_debouncer;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 3;
`ifdef SWITCH_DEBOUNCER_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] clr_pending = '0;
  logic [W-1:0] irq_mask = '0;
  logic [W-1:0] sw_db;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic [W-1:0] pending;
  logic         irq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  switch_debouncer #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_raw     (sw_raw),
    .clr_pending(clr_pending),
    .irq_mask   (irq_mask),
    .sw_db      (sw_db),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .pending    (pending),
    .irq        (irq)
  );

  // Reference: a level is accepted once the synchronised value has differed
  // from it on each of the last D edges (hist[k] = raw sampled k+1 edges ago).
  logic [W-1:0] hist [0:D];
  logic [W-1:0] m_db, m_rise, m_fall, m_pend, m_flip;
  logic [W-1:0] e_pend;
  logic         e_irq;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k <= D; k++) hist[k] = '0;
      m_db = '0; m_rise = '0; m_fall = '0; m_pend = '0;
    end else begin
      m_pend = (m_pend & ~clr_pending) | m_rise | m_fall;
      m_flip = '1;
      for (int k = 1; k <= D; k++) m_flip = m_flip & (hist[k] ^ m_db);
      m_rise = m_flip & ~m_db;
      m_fall = m_flip & m_db;
      m_db   = m_db ^ m_flip;
      for (int k = D; k >= 1; k--) hist[k] = hist[k-1];
      hist[0] = sw_raw;
    end
  end

  assign e_pend = m_pend & {W{IRQ_EN}};
  assign e_irq  = |(e_pend & irq_mask);

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    wait_neg(2);
    n_cmp++;
    if ({sw_db, sw_rise, sw_fall, pending} !== '0 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got db=%h rise=%h fall=%h pend=%h irq=%b want all 0",
               sw_db, sw_rise, sw_fall, pending, irq);
    end
    reset = 1'b1;
  endtask

  task automatic test_step();
    irq_mask = 8'h01;
    sw_raw   = 8'h01;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (sw_db !== 8'h00) begin
        n_err++;
        $display("FAIL step_early edge %0d: got db=%h want 00", k, sw_db);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (sw_db !== 8'h01 || sw_rise !== 8'h01 || sw_fall !== 8'h00) begin
      n_err++;
      $display("FAIL step_edge6: got db=%h rise=%h fall=%h want 01/01/00", sw_db, sw_rise, sw_fall);
    end
    @(negedge clk);
    n_cmp++;
    if (sw_rise !== 8'h00 || pending !== (IRQ_EN ? 8'h01 : 8'h00) || irq !== IRQ_EN) begin
      n_err++;
      $display("FAIL step_pending: got rise=%h pend=%h irq=%b want 00/%h/%b",
               sw_rise, pending, irq, IRQ_EN ? 8'h01 : 8'h00, IRQ_EN);
    end
    irq_mask = 8'h00;
    #1;
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL step_masked_irq: got irq=%b want 0", irq);
    end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    sw_raw = 8'h09;
    wait_neg(3);
    sw_raw = 8'h01;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_cmp++;
      if (sw_db !== 8'h01 || sw_rise !== 8'h00 || pending !== (IRQ_EN ? 8'h01 : 8'h00)) begin
        n_err++;
        $display("FAIL glitch3 cycle %0d: got db=%h rise=%h pend=%h want 01/00/%h",
                 k, sw_db, sw_rise, pending, IRQ_EN ? 8'h01 : 8'h00);
      end
    end
    sw_raw = 8'h09;
    wait_neg(4);
    sw_raw = 8'h01;
    @(negedge clk);
    n_cmp++;
    if (sw_db !== 8'h01) begin
      n_err++;
      $display("FAIL glitch4_early: got db=%h want 01", sw_db);
    end
    @(negedge clk);
    n_cmp++;
    if (sw_db !== 8'h09 || sw_rise !== 8'h08) begin
      n_err++;
      $display("FAIL glitch4_rise: got db=%h rise=%h want 09/08", sw_db, sw_rise);
    end
    wait_neg(10);
    n_cmp++;
    if (sw_db !== 8'h01 || pending !== (IRQ_EN ? 8'h09 : 8'h00)) begin
      n_err++;
      $display("FAIL glitch4_settle: got db=%h pend=%h want 01/%h", sw_db, pending, IRQ_EN ? 8'h09 : 8'h00);
    end
    clr_pending = 8'hFF;
    @(negedge clk);
    clr_pending = 8'h00;
    n_cmp++;
    if (pending !== 8'h00) begin
      n_err++;
      $display("FAIL glitch_clear: got pend=%h want 00", pending);
    end
  endtask

  task automatic test_release();
    irq_mask = 8'h01;
    sw_raw   = 8'h00;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (sw_db !== 8'h01 || sw_fall !== 8'h00) begin
        n_err++;
        $display("FAIL release_early edge %0d: got db=%h fall=%h want 01/00", k, sw_db, sw_fall);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (sw_db !== 8'h00 || sw_fall !== 8'h01 || sw_rise !== 8'h00) begin
      n_err++;
      $display("FAIL release_edge6: got db=%h fall=%h rise=%h want 00/01/00", sw_db, sw_fall, sw_rise);
    end
    @(negedge clk);
    n_cmp++;
    if (sw_fall !== 8'h00 || pending !== (IRQ_EN ? 8'h01 : 8'h00) || irq !== IRQ_EN) begin
      n_err++;
      $display("FAIL release_pending: got fall=%h pend=%h irq=%b want 00/%h/%b",
               sw_fall, pending, irq, IRQ_EN ? 8'h01 : 8'h00, IRQ_EN);
    end
    clr_pending = 8'h01;
    @(negedge clk);
    clr_pending = 8'h00;
    n_cmp++;
    if (pending !== 8'h00 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL release_clear: got pend=%h irq=%b want 00/0", pending, irq);
    end
  endtask

  task automatic test_collision();
    sw_raw = 8'h04;
    wait_neg(6);
    n_cmp++;
    if (sw_rise !== 8'h04) begin
      n_err++;
      $display("FAIL collision_rise: got rise=%h want 04", sw_rise);
    end
    clr_pending = 8'h04;
    @(negedge clk);
    clr_pending = 8'h00;
    n_cmp++;
    if (pending !== (IRQ_EN ? 8'h04 : 8'h00)) begin
      n_err++;
      $display("FAIL collision_set_wins: got pend=%h want %h", pending, IRQ_EN ? 8'h04 : 8'h00);
    end
  endtask

  task automatic test_reset_mid();
    irq_mask = 8'hFF;
    sw_raw   = 8'hFF;
    wait_neg(4);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({sw_db, sw_rise, sw_fall, pending} !== '0 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_clear: got db=%h rise=%h fall=%h pend=%h irq=%b want all 0",
               sw_db, sw_rise, sw_fall, pending, irq);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (sw_db !== 8'h00) begin
        n_err++;
        $display("FAIL reset_mid_early edge %0d: got db=%h want 00", k, sw_db);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (sw_db !== 8'hFF || sw_rise !== 8'hFF) begin
      n_err++;
      $display("FAIL reset_mid_rise: got db=%h rise=%h want FF/FF", sw_db, sw_rise);
    end
    @(negedge clk);
    n_cmp++;
    if (sw_rise !== 8'h00 || pending !== (IRQ_EN ? 8'hFF : 8'h00) || irq !== IRQ_EN) begin
      n_err++;
      $display("FAIL reset_mid_pending: got rise=%h pend=%h irq=%b want 00/%h/%b",
               sw_rise, pending, irq, IRQ_EN ? 8'hFF : 8'h00, IRQ_EN);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] flips;
    int           bad;
    bad = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      n_cmp++;
      if (sw_db !== m_db || sw_rise !== m_rise || sw_fall !== m_fall ||
          pending !== e_pend || irq !== e_irq) begin
        n_err++;
        if (bad < 10)
          $display("FAIL random cycle %0d: got db=%h r=%h f=%h p=%h i=%b want db=%h r=%h f=%h p=%h i=%b",
                   c, sw_db, sw_rise, sw_fall, pending, irq, m_db, m_rise, m_fall, e_pend, e_irq);
        bad++;
      end
      if (c == 1500) begin
        reset = 1'b0;
        #2;
        reset = 1'b1;
      end
      for (int b = 0; b < W; b++) flips[b] = ($urandom_range(0, 5) == 0);
      sw_raw      = sw_raw ^ flips;
      clr_pending = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
      if ($urandom_range(0, 31) == 0) irq_mask = W'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_glitch();
    test_release();
    test_collision();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
